clk_enable_ctrl: RTL and testbench

CLK_ENABLE_CTRL -- requirements
Module: clk_enable_ctrl

---
 rtl/clk_ctrl_pkg.sv | 15 +
 rtl/clk_enable_ctrl_if.sv | 16 +
 rtl/clk_period_counter.sv | 42 ++++
 rtl/clk_enable_ctrl.sv | 147 ++++++++++++++
 tb/tb_clk_enable_ctrl.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the clock-enable controller: FSM state encoding,
// the smallest legal divide ratio, and default parameter values.
package clk_ctrl_pkg;

  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned DEFAULT_DIV_DEF = 4;
  localparam int unsigned MIN_DIV         = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_PEND = 2'd2
  } state_e;

endpackage

// File: rtl/clk_enable_ctrl_if.sv
// Divide-ratio configuration handshake.
//   cfg_div   : requested divide ratio N
//   cfg_valid : cfg_div valid (source side)
//   cfg_ready : controller can accept cfg_div
//   cfg_err   : one-cycle pulse, an accepted ratio was rejected (N < 2)
interface clk_enable_ctrl_if #(
  parameter int unsigned CNT_W = clk_ctrl_pkg::CNT_W_DEF
);
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_valid;
  logic             cfg_ready;
  logic             cfg_err;

  modport master (output cfg_div, output cfg_valid, input cfg_ready, input cfg_err);
  modport slave  (input cfg_div, input cfg_valid, output cfg_ready, output cfg_err);
endinterface

// File: rtl/clk_period_counter.sv
// Period counter: counts 0..div-1 and wraps, with synchronous clear.
//   clk_in, reset_n : clock, async active-low reset
//   clear           : force the counter to 0 on the next edge
//   advance         : count this cycle
//   div             : active divide ratio (>= 2)
//   cnt             : registered count
//   cnt_nxt_c       : combinational next count (lets the owner register decodes)
//   wrap_c          : combinational, cnt is at div-1
module clk_period_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             advance,
  input  logic [CNT_W-1:0] div,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt_c,
  output logic             wrap_c
);

  assign wrap_c = (cnt == (div - CNT_W'(1)));

  // Next count; wrap is checked before increment so div = 2^CNT_W-1 never overflows
  always_comb begin
    cnt_nxt_c = cnt;
    if (clear) begin
      cnt_nxt_c = '0;
    end else if (advance) begin
      cnt_nxt_c = wrap_c ? '0 : (cnt + CNT_W'(1));
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt_c;
    end
  end

endmodule

// File: rtl/clk_enable_ctrl.sv
// Clock-enable controller: produces a one-cycle enable strobe and a divided
// square wave from clk_in at a run-time programmable ratio. Ratio changes
// requested while running are deferred to the end of the current period.
//   clk_in, reset_n : clock, async active-low reset
//   run             : 1 = generate strobes, 0 = halt
//   cfg             : ratio configuration handshake (slave side)
//   clk_en          : strobe, high when cnt == N-1
//   clk_div_out     : high while cnt < N/2
//   locked          : outputs are running at the active ratio
//   cur_div         : active divide ratio
module clk_enable_ctrl
  import clk_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             run,
  clk_enable_ctrl_if.slave cfg,
  output logic             clk_en,
  output logic             clk_div_out,
  output logic             locked,
  output logic [CNT_W-1:0] cur_div
);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN = CNT_W'(MIN_DIV);

  state_e           state_q;
  state_e           state_n;
  logic [CNT_W-1:0] pend_q;
  logic [CNT_W-1:0] pend_n;
  logic [CNT_W-1:0] div_n;
  logic             err_n;
  logic             clear;
  logic             advance;
  logic             xfer;
  logic             div_ok;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             wrap;
  logic             en_n;
  logic             dout_n;
  logic             lock_n;
  logic             ready_n;

  clk_period_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk_in    (clk_in),
    .reset_n   (reset_n),
    .clear     (clear),
    .advance   (advance),
    .div       (cur_div),
    .cnt       (cnt),
    .cnt_nxt_c (cnt_nxt),
    .wrap_c    (wrap)
  );

  assign xfer   = cfg.cfg_valid && cfg.cfg_ready;
  assign div_ok = (cfg.cfg_div >= DIV_MIN);

  // Next state, ratio registers and counter control
  always_comb begin
    state_n = state_q;
    div_n   = cur_div;
    pend_n  = pend_q;
    err_n   = 1'b0;
    clear   = 1'b0;
    advance = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        clear = 1'b1;
        if (xfer) begin
          // A transfer in IDLE is consumed on its own; run is honoured next cycle
          err_n = !div_ok;
          if (div_ok) div_n = cfg.cfg_div;
        end else if (run) begin
          state_n = ST_RUN;
        end
      end
      ST_RUN: begin
        advance = 1'b1;
        if (xfer && !div_ok) err_n = 1'b1;
        if (!run) begin
          state_n = ST_IDLE;
          clear   = 1'b1;
          if (xfer && div_ok) div_n = cfg.cfg_div;
        end else if (xfer && div_ok) begin
          pend_n  = cfg.cfg_div;
          state_n = ST_PEND;
        end
      end
      ST_PEND: begin
        advance = 1'b1;
        if (!run) begin
          state_n = ST_IDLE;
          clear   = 1'b1;
          div_n   = pend_q;
        end else if (wrap) begin
          // Counter wraps to 0 on this edge, so the new ratio starts a clean period
          state_n = ST_RUN;
          div_n   = pend_q;
        end
      end
      default: begin
        state_n = ST_IDLE;
        clear   = 1'b1;
      end
    endcase
  end

  // Output decodes from next-cycle values so registered outputs line up with cnt
  always_comb begin
    en_n    = 1'b0;
    dout_n  = 1'b0;
    lock_n  = 1'b0;
    ready_n = (state_n != ST_PEND);
    if (state_n != ST_IDLE) begin
      en_n   = (cnt_nxt == (div_n - CNT_W'(1)));
      dout_n = (cnt_nxt < (div_n >> 1));
      lock_n = en_n || locked;
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      cur_div       <= DIV_RST;
      pend_q        <= DIV_RST;
      clk_en        <= 1'b0;
      clk_div_out   <= 1'b0;
      locked        <= 1'b0;
      cfg.cfg_err   <= 1'b0;
      cfg.cfg_ready <= 1'b1;
    end else begin
      state_q       <= state_n;
      cur_div       <= div_n;
      pend_q        <= pend_n;
      clk_en        <= en_n;
      clk_div_out   <= dout_n;
      locked        <= lock_n;
      cfg.cfg_err   <= err_n;
      cfg.cfg_ready <= ready_n;
    end
  end

endmodule

// File: tb/tb_clk_enable_ctrl.sv
// Directed bench for clk_enable_ctrl: a vector table for the default-ratio
// run, deferred ratio change, run-drop transfer and rejected ratios, then
// hand-written sequences for PEND exit, async reset and extreme ratios.
module tb_clk_enable_ctrl;

  localparam int unsigned CNT_W = 8;

  logic             clk_in;
  logic             reset_n;
  logic             run;
  logic             clk_en;
  logic             clk_div_out;
  logic             locked;
  logic [CNT_W-1:0] cur_div;

  clk_enable_ctrl_if #(.CNT_W(CNT_W)) cfg_bus ();

  clk_enable_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(4)) dut (
    .clk_in      (clk_in),
    .reset_n     (reset_n),
    .run         (run),
    .cfg         (cfg_bus),
    .clk_en      (clk_en),
    .clk_div_out (clk_div_out),
    .locked      (locked),
    .cur_div     (cur_div)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    bit       run;
    bit       valid;
    bit [7:0] div;
    bit       en;
    bit       dout;
    bit       lk;
    bit       rdy;
    bit       err;
    bit [7:0] cur;
  } vec_t;

  vec_t vec [21];
  int checks = 0;
  int errors = 0;
  int rdy_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Find a strobe, then measure reps periods: length and high-phase count
  task automatic check_periods(input int n, input int reps, input string name);
    int  cyc;
    int  hi;
    bit  seen;
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      step();
      seen = clk_en;
    end
    chk({name, " first strobe"}, 32'(seen), 32'd1);
    for (int r = 0; r < reps; r++) begin
      cyc  = 0;
      hi   = 0;
      seen = 1'b0;
      while (!seen && cyc < 600) begin
        step();
        cyc++;
        if (clk_div_out) hi++;
        seen = clk_en;
      end
      chk($sformatf("%s period %0d", name, r), 32'(cyc), 32'(n));
      chk($sformatf("%s high %0d", name, r), 32'(hi), 32'(n / 2));
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " clk_en"}, 32'(clk_en), 32'd0);
    chk({name, " clk_div_out"}, 32'(clk_div_out), 32'd0);
    chk({name, " locked"}, 32'(locked), 32'd0);
    chk({name, " cfg_err"}, 32'(cfg_bus.cfg_err), 32'd0);
    chk({name, " cfg_ready"}, 32'(cfg_bus.cfg_ready), 32'd1);
    chk({name, " cur_div"}, 32'(cur_div), 32'd4);
  endtask

  initial begin
    //          run val div  en do lk rd er cur
    vec[0]  = '{1, 0, 0,   0, 1, 0, 1, 0, 4};
    vec[1]  = '{1, 0, 0,   0, 1, 0, 1, 0, 4};
    vec[2]  = '{1, 0, 0,   0, 0, 0, 1, 0, 4};
    vec[3]  = '{1, 0, 0,   1, 0, 1, 1, 0, 4};
    vec[4]  = '{1, 0, 0,   0, 1, 1, 1, 0, 4};
    vec[5]  = '{1, 0, 0,   0, 1, 1, 1, 0, 4};
    vec[6]  = '{1, 1, 6,   0, 0, 1, 0, 0, 4};
    vec[7]  = '{1, 0, 0,   1, 0, 1, 0, 0, 4};
    vec[8]  = '{1, 0, 0,   0, 1, 1, 1, 0, 6};
    vec[9]  = '{1, 0, 0,   0, 1, 1, 1, 0, 6};
    vec[10] = '{1, 0, 0,   0, 1, 1, 1, 0, 6};
    vec[11] = '{1, 0, 0,   0, 0, 1, 1, 0, 6};
    vec[12] = '{1, 0, 0,   0, 0, 1, 1, 0, 6};
    vec[13] = '{1, 0, 0,   1, 0, 1, 1, 0, 6};
    vec[14] = '{1, 0, 0,   0, 1, 1, 1, 0, 6};
    vec[15] = '{0, 1, 4,   0, 0, 0, 1, 0, 4};
    vec[16] = '{1, 0, 0,   0, 1, 0, 1, 0, 4};
    vec[17] = '{1, 1, 1,   0, 1, 0, 1, 1, 4};
    vec[18] = '{1, 1, 0,   0, 0, 0, 1, 1, 4};
    vec[19] = '{1, 0, 0,   1, 0, 1, 1, 0, 4};
    vec[20] = '{1, 0, 0,   0, 1, 1, 1, 0, 4};

    reset_n           = 1'b0;
    run               = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_div   = '0;
    repeat (3) step();
    chk_reset_outputs("reset");
    @(negedge clk_in);
    reset_n = 1'b1;
    step();

    for (int i = 0; i < 21; i++) begin
      run               = vec[i].run;
      cfg_bus.cfg_valid = vec[i].valid;
      cfg_bus.cfg_div   = vec[i].div;
      step();
      chk($sformatf("v%0d clk_en", i), 32'(clk_en), 32'(vec[i].en));
      chk($sformatf("v%0d clk_div_out", i), 32'(clk_div_out), 32'(vec[i].dout));
      chk($sformatf("v%0d locked", i), 32'(locked), 32'(vec[i].lk));
      chk($sformatf("v%0d cfg_ready", i), 32'(cfg_bus.cfg_ready), 32'(vec[i].rdy));
      chk($sformatf("v%0d cfg_err", i), 32'(cfg_bus.cfg_err), 32'(vec[i].err));
      chk($sformatf("v%0d cur_div", i), 32'(cur_div), 32'(vec[i].cur));
    end

    // run drops while a ratio of 10 is pending
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 8'd10;
    step();
    chk("pend10 cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    chk("pend10 cur_div", 32'(cur_div), 32'd4);
    cfg_bus.cfg_valid = 1'b0;
    run               = 1'b0;
    step();
    chk("drop locked", 32'(locked), 32'd0);
    chk("drop cur_div", 32'(cur_div), 32'd10);
    chk("drop clk_en", 32'(clk_en), 32'd0);
    chk("drop clk_div_out", 32'(clk_div_out), 32'd0);
    chk("drop cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    run = 1'b1;
    check_periods(10, 2, "n10");

    // async reset in PEND at cnt=2 discards the pending ratio
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 8'd6;
    step();
    cfg_bus.cfg_valid = 1'b0;
    step();
    step();
    chk("prerst cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    chk("prerst clk_div_out", 32'(clk_div_out), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("async rst");
    @(negedge clk_in);
    reset_n = 1'b1;
    check_periods(4, 2, "post rst");

    // cfg_valid held high: one transfer per RUN visit, N=2 then N=255
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = 8'd2;
    check_periods(2, 3, "n2");
    rdy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (cfg_bus.cfg_ready) rdy_cnt++;
    end
    chk("n2 ready visits", 32'(rdy_cnt), 32'd4);
    chk("n2 cur_div", 32'(cur_div), 32'd2);
    cfg_bus.cfg_div = 8'd255;
    check_periods(255, 2, "n255");
    chk("n255 cur_div", 32'(cur_div), 32'd255);
    cfg_bus.cfg_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
